// File: rtl/umi_regbank_pkg.sv
// umi_regbank_pkg: shared decode constants and byte-lane helpers for the UMI register bank
package umi_regbank_pkg;
  localparam int RW_DEF = 64;
  localparam int NREG_DEF = 16;
  localparam int BO = $clog2(RW_DEF / 8);
  localparam int IW = $clog2(NREG_DEF);
  function automatic logic [31:0] byte_mask(input logic [3:0] size, input logic [4:0] off);
    logic [63:0] m;
    m = ((64'd1 << (32'd1 << size)) - 64'd1) << off;
    return m[31:0];
  endfunction
  function automatic logic legal_access(input logic [3:0] size, input logic [4:0] off, input int bo);
    return (int'(size) <= bo) && ((off & 5'((32'd1 << size) - 32'd1)) == 5'd0);
  endfunction
endpackage

// File: rtl/umi_regbank_wmask.sv
// umi_regbank_wmask: size/offset to lane masks, shifted write data and legality
module umi_regbank_wmask
  import umi_regbank_pkg::*;
#(
  parameter int RW = 64
) (
  input  logic [3:0]    size,
  input  logic [4:0]    off,
  input  logic [RW-1:0] wrdata,
  output logic [RW-1:0] wmask,
  output logic [RW-1:0] rmask,
  output logic [RW-1:0] wdata,
  output logic          legal
);
  localparam int NB = RW / 8;
  localparam int BOFF = $clog2(NB);
  logic [NB-1:0] bw, br;
  always_comb begin
    bw = NB'(byte_mask(size, off));
    br = NB'(byte_mask(size, 5'd0));
    for (int b = 0; b < NB; b++) begin
      wmask[8*b +: 8] = {8{bw[b]}};
      rmask[8*b +: 8] = {8{br[b]}};
    end
    wdata = wrdata << {off, 3'b000};
    legal = legal_access(size, off, BOFF);
  end
endmodule

// File: rtl/umi_regbank.sv
// umi_regbank: RW register bank with W1C status register and interrupt behind the UMI register interface
module umi_regbank
  import umi_regbank_pkg::*;
#(
  parameter int AW = 64,
  parameter int RW = RW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int STATUSIDX = 0,
  parameter int IRQENIDX = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      reg_addr,
  input  logic               reg_write,
  input  logic               reg_read,
  input  logic [3:0]         reg_size,
  input  logic [RW-1:0]      reg_wrdata,
  output logic [RW-1:0]      reg_rddata,
  output logic               reg_err,
  output logic [NREG*RW-1:0] ctrl_q,
  input  logic [RW-1:0]      status_set,
  output logic               irq
);
  localparam int BOFF = $clog2(RW / 8);
  localparam int IDXW = $clog2(NREG);
  logic [4:0] off;
  logic [IDXW-1:0] idx;
  logic [RW-1:0] wm, rm, wd, rd_val, rddata_q, rddata_d;
  logic legal, wen, err_q, err_d, irq_q, irq_d;
  logic [RW-1:0] regs_q [NREG];
  logic [RW-1:0] regs_d [NREG];
  assign off = 5'(reg_addr & AW'(RW / 8 - 1));
  assign idx = IDXW'(reg_addr >> BOFF);
  umi_regbank_wmask #(.RW(RW)) u_wmask (
    .size(reg_size), .off(off), .wrdata(reg_wrdata),
    .wmask(wm), .rmask(rm), .wdata(wd), .legal(legal)
  );
  always_comb begin
    wen = 1'b0;
    rd_val = (regs_q[idx] >> {off, 3'b000}) & rm;
    rddata_d = (reg_read && !reg_write) ? (legal ? rd_val : '0) : rddata_q;
    err_d = (reg_read || reg_write) && (!legal || (reg_read && reg_write));
    irq_d = |(regs_q[STATUSIDX] & regs_q[IRQENIDX]);
    for (int i = 0; i < NREG; i++) begin
      wen = reg_write && legal && (idx == IDXW'(i));
      // hardware set is ORed last so it beats a same-cycle software clear
      regs_d[i] = (i == STATUSIDX) ? ((regs_q[i] & ~(wen ? (wd & wm) : '0)) | status_set)
                                   : (wen ? ((regs_q[i] & ~wm) | (wd & wm)) : regs_q[i]);
      ctrl_q[i*RW +: RW] = regs_q[i];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      rddata_q <= '0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rddata_q <= rddata_d;
      err_q <= err_d;
      irq_q <= irq_d;
    end
  end
  assign reg_rddata = rddata_q;
  assign reg_err = err_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_umi_regbank.sv
// tb_umi_regbank: directed and randomized checks of umi_regbank against a byte-level reference model
module tb_umi_regbank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] reg_addr = '0;
  logic reg_write = 1'b0, reg_read = 1'b0;
  logic [3:0] reg_size = '0;
  logic [63:0] reg_wrdata = '0, status_set = '0;
  logic [63:0] reg_rddata;
  logic reg_err, irq;
  logic [16*64-1:0] ctrl_q;
  int checks = 0;
  int failures = 0;
  logic [63:0] mem [16];
  logic [63:0] exp_rd = '0;
  logic exp_err = 1'b0, exp_irq = 1'b0;

  always #5 clk = ~clk;

  umi_regbank dut (
    .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_write(reg_write),
    .reg_read(reg_read), .reg_size(reg_size), .reg_wrdata(reg_wrdata),
    .reg_rddata(reg_rddata), .reg_err(reg_err), .ctrl_q(ctrl_q),
    .status_set(status_set), .irq(irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("rddata", reg_rddata, exp_rd);
    chk("err", {63'd0, reg_err}, {63'd0, exp_err});
    chk("irq", {63'd0, irq}, {63'd0, exp_irq});
    for (int i = 0; i < 16; i++) chk($sformatf("ctrl%0d", i), ctrl_q[i*64 +: 64], mem[i]);
  endtask

  // one bus cycle: apply inputs, clock, advance the model, compare everything
  task automatic cyc(input logic w, input logic r, input logic [63:0] a, input logic [3:0] s,
                     input logic [63:0] d, input logic [63:0] ss);
    int o, idx, n;
    logic lg;
    logic [63:0] v;
    reg_write = w; reg_read = r; reg_addr = a; reg_size = s; reg_wrdata = d; status_set = ss;
    @(posedge clk);
    #1;
    o = int'(a[2:0]);
    idx = int'(a[6:3]);
    n = 1 << s;
    lg = (s <= 4'd3) && (o % n == 0);
    exp_irq = |(mem[0] & mem[1]);
    exp_err = (w || r) && (!lg || (w && r));
    if (r && !w) begin
      v = '0;
      if (lg) for (int k = 0; k < n; k++) v[8*k +: 8] = mem[idx][8*(o+k) +: 8];
      exp_rd = v;
    end
    if (w && lg)
      for (int k = 0; k < n; k++)
        if (idx == 0) mem[0][8*(o+k) +: 8] = mem[0][8*(o+k) +: 8] & ~d[8*k +: 8];
        else mem[idx][8*(o+k) +: 8] = d[8*k +: 8];
    mem[0] = mem[0] | ss;
    chk_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 64'd0, 4'd0, 64'd0, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    reset = 1'b0;
    idle();
    // full-width write and read
    cyc(1'b1, 1'b0, 64'h18, 4'd3, 64'hDEADBEEF_CAFEF00D, 64'd0);
    cyc(1'b0, 1'b1, 64'h18, 4'd3, 64'd0, 64'd0);
    chk("full_rd", reg_rddata, 64'hDEADBEEF_CAFEF00D);
    chk("full_ctrl", ctrl_q[3*64 +: 64], 64'hDEADBEEF_CAFEF00D);
    // byte write into the middle of a register
    cyc(1'b1, 1'b0, 64'h10, 4'd3, 64'h11223344_55667788, 64'd0);
    cyc(1'b1, 1'b0, 64'h13, 4'd0, 64'hAA, 64'd0);
    chk("byte_ctrl", ctrl_q[2*64 +: 64], 64'h11223344_AA667788);
    cyc(1'b0, 1'b1, 64'h13, 4'd0, 64'd0, 64'd0);
    chk("byte_rd", reg_rddata, 64'hAA);
    // misaligned accesses
    cyc(1'b1, 1'b0, 64'h0A, 4'd2, 64'hFFFF_FFFF, 64'd0);
    chk("mis_wr_err", {63'd0, reg_err}, 64'd1);
    chk("mis_wr_ctrl", ctrl_q[1*64 +: 64], 64'd0);
    cyc(1'b0, 1'b1, 64'h09, 4'd1, 64'd0, 64'd0);
    chk("mis_rd_err", {63'd0, reg_err}, 64'd1);
    chk("mis_rd_data", reg_rddata, 64'd0);
    idle();
    chk("err_pulse", {63'd0, reg_err}, 64'd0);
    // read and write together: write wins, read ignored
    cyc(1'b1, 1'b1, 64'h20, 4'd3, 64'h0123_4567_89AB_CDEF, 64'd0);
    chk("both_err", {63'd0, reg_err}, 64'd1);
    // W1C with hardware-set collision
    cyc(1'b0, 1'b0, 64'd0, 4'd0, 64'd0, 64'h5);
    chk("st_set", ctrl_q[63:0], 64'h5);
    cyc(1'b1, 1'b0, 64'h0, 4'd3, 64'h1, 64'h1);
    chk("st_collide", ctrl_q[63:0], 64'h5);
    cyc(1'b1, 1'b0, 64'h0, 4'd3, 64'h4, 64'd0);
    chk("st_clr", ctrl_q[63:0], 64'h1);
    // interrupt timing
    cyc(1'b1, 1'b0, 64'h8, 4'd3, 64'h2, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 4'd0, 64'd0, 64'h2);
    chk("irq_lag", {63'd0, irq}, 64'd0);
    idle();
    chk("irq_rise", {63'd0, irq}, 64'd1);
    cyc(1'b1, 1'b0, 64'h0, 4'd3, 64'h2, 64'd0);
    chk("irq_hold", {63'd0, irq}, 64'd1);
    idle();
    chk("irq_fall", {63'd0, irq}, 64'd0);
    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      logic [1:0] op;
      logic [63:0] a;
      op = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      a[63:7] = ($urandom_range(0, 3) == 0) ? a[63:7] : '0;
      cyc(op[0], op[1], a, 4'($urandom_range(0, 5)), {$urandom, $urandom},
          ($urandom_range(0, 5) == 0) ? 64'(1) << $urandom_range(0, 63) : 64'd0);
    end
    // reset while a read is in flight
    cyc(1'b1, 1'b0, 64'h8, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    idle();
    chk("irq_pre", {63'd0, irq}, 64'd1);
    cyc(1'b1, 1'b0, 64'h18, 4'd3, 64'h5A5A_5A5A_A5A5_A5A5, 64'd0);
    cyc(1'b0, 1'b1, 64'h18, 4'd3, 64'd0, 64'd0);
    chk("rd_pre", reg_rddata, 64'h5A5A_5A5A_A5A5_A5A5);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_rddata", reg_rddata, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_ctrl%0d", i), ctrl_q[i*64 +: 64], 64'd0);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    exp_rd = '0;
    exp_irq = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 64'h18, 4'd3, 64'd0, 64'd0);
    chk("rst_rd", reg_rddata, 64'd0);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
